// File: rtl/cave_input_mapper.sv
// Keyboard/joystick front end for the Cave core. It decodes ps2_key events into held-key state,
// merges that state with the HPS joystick words, and registers the per-player buses for Main.
module cave_input_mapper #(
  parameter int          NUM_PLAYERS  = 2,
  parameter int          JOY_WIDTH    = 11,
  parameter logic [15:0] COIN_HOLD    = 16'd50000,
  parameter int          PAUSE_TOGGLE = 0
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic [10:0]              ps2_key,
  input  logic [JOY_WIDTH-1:0]     joystick_0,
  input  logic [JOY_WIDTH-1:0]     joystick_1,
  output logic [NUM_PLAYERS*10-1:0] player,
  output logic [1:0]               service
);

  logic       prev_tog;
  logic       key_event;
  logic [9:0] key_p1;
  logic [8:0] key_p2;
  logic       svc1_key;
  logic       svc2_key;
  logic       unused_inputs;

  // Reorders a joystick word {pause..b1,U,D,L,R} into the output order {pause..b1,R,L,D,U}.
  function automatic logic [9:0] joy_map(input logic [9:0] j);
    return {j[9:4], j[0], j[1], j[2], j[3]};
  endfunction

  assign key_event     = ps2_key[10] != prev_tog;
  assign unused_inputs = ^{joystick_0, joystick_1, key_p2};

  always_ff @(posedge clock) begin
    // prev_tog tracks the toggle during reset too, so no event is decoded when reset is released.
    prev_tog <= ps2_key[10];
    if (reset) begin
      key_p1   <= '0;
      key_p2   <= '0;
      svc1_key <= 1'b0;
      svc2_key <= 1'b0;
    end else if (key_event) begin
      if (ps2_key[8]) begin
        case (ps2_key[7:0])
          8'h75:   key_p1[0] <= ps2_key[9];
          8'h72:   key_p1[1] <= ps2_key[9];
          8'h6B:   key_p1[2] <= ps2_key[9];
          8'h74:   key_p1[3] <= ps2_key[9];
          8'h14:   key_p1[4] <= ps2_key[9];
          default: ;
        endcase
      end else begin
        case (ps2_key[7:0])
          8'h14:   key_p1[4] <= ps2_key[9];
          8'h11:   key_p1[5] <= ps2_key[9];
          8'h29:   key_p1[6] <= ps2_key[9];
          8'h16:   key_p1[7] <= ps2_key[9];
          8'h2E:   key_p1[8] <= ps2_key[9];
          8'h4D:   key_p1[9] <= ps2_key[9];
          8'h2D:   key_p2[0] <= ps2_key[9];
          8'h2B:   key_p2[1] <= ps2_key[9];
          8'h23:   key_p2[2] <= ps2_key[9];
          8'h34:   key_p2[3] <= ps2_key[9];
          8'h1C:   key_p2[4] <= ps2_key[9];
          8'h1B:   key_p2[5] <= ps2_key[9];
          8'h15:   key_p2[6] <= ps2_key[9];
          8'h1E:   key_p2[7] <= ps2_key[9];
          8'h36:   key_p2[8] <= ps2_key[9];
          8'h46:   svc1_key  <= ps2_key[9];
          8'h45:   svc2_key  <= ps2_key[9];
          default: ;
        endcase
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) service <= '0;
    else       service <= {svc2_key, svc1_key};
  end

  for (genvar p = 0; p < NUM_PLAYERS; p++) begin : g_player
    logic [9:0]  raw;
    logic [9:0]  out_q;
    logic [15:0] cnt;
    logic        coin_prev;
    logic        pause_prev;
    logic        pause_latch;
    logic        coin_rise;
    logic        pause_rise;
    logic        coin_next;
    logic        pause_next;

    if (p == 0) begin : g_p1
      assign raw = key_p1 | joy_map(joystick_0[9:0]);
    end else begin : g_p2
      assign raw = {1'b0, key_p2} | joy_map(joystick_1[9:0]);
    end

    // Edge-driven outputs use the post-edge value, keeping them on the same 1-clock latency as raw bits.
    always_comb begin
      coin_rise  = raw[8] & ~coin_prev;
      pause_rise = raw[9] & ~pause_prev;
      coin_next  = raw[8] | (cnt != '0);
      pause_next = (PAUSE_TOGGLE != 0) ? (pause_latch ^ pause_rise) : raw[9];
    end

    always_ff @(posedge clock) begin
      if (reset) begin
        coin_prev   <= 1'b0;
        pause_prev  <= 1'b0;
        pause_latch <= 1'b0;
        cnt         <= '0;
        out_q       <= '0;
      end else begin
        coin_prev  <= raw[8];
        pause_prev <= raw[9];
        if (pause_rise) pause_latch <= ~pause_latch;
        if (coin_rise)        cnt <= COIN_HOLD;
        else if (cnt != '0)   cnt <= cnt - 16'd1;
        out_q <= {pause_next, coin_next, raw[7:0]};
      end
    end

    assign player[p*10 +: 10] = out_q;
  end

endmodule

// File: tb/tb_cave_input_mapper.sv
// Directed bench for cave_input_mapper. It drives a two-player instance (coin hold 10, pause toggle)
// and a one-player instance (no stretch, momentary pause) from shared inputs, and checks both against queued expectations.
module tb_cave_input_mapper;

  typedef struct {
    int          cyc;
    logic [19:0] pa;
    logic [1:0]  sa;
    logic [9:0]  pb;
    logic [1:0]  sb;
    string       tag;
  } exp_t;

  logic        clock = 1'b0;
  logic        reset;
  logic [10:0] ps2_key;
  logic [10:0] joystick_0;
  logic [10:0] joystick_1;
  logic [19:0] player_a;
  logic [1:0]  service_a;
  logic [9:0]  player_b;
  logic [1:0]  service_b;

  int tests = 0;
  int fails = 0;
  int cycle = 0;

  logic [19:0] ea;
  logic [1:0]  esa;
  logic [9:0]  eb;
  logic [1:0]  esb;
  string       tag;
  exp_t        sb_q[$];
  int          map_out[8] = '{3, 2, 1, 0, 4, 5, 6, 7};

  always #5 clock = ~clock;

  cave_input_mapper #(
    .NUM_PLAYERS(2), .JOY_WIDTH(11), .COIN_HOLD(16'd10), .PAUSE_TOGGLE(1)
  ) dut_a (
    .clock(clock), .reset(reset), .ps2_key(ps2_key),
    .joystick_0(joystick_0), .joystick_1(joystick_1),
    .player(player_a), .service(service_a)
  );

  cave_input_mapper #(
    .NUM_PLAYERS(1), .JOY_WIDTH(11), .COIN_HOLD(16'd0), .PAUSE_TOGGLE(0)
  ) dut_b (
    .clock(clock), .reset(reset), .ps2_key(ps2_key),
    .joystick_0(joystick_0), .joystick_1(joystick_1),
    .player(player_b), .service(service_b)
  );

  task automatic check_due();
    int   i;
    exp_t e;
    i = 0;
    while (i < sb_q.size()) begin
      if (sb_q[i].cyc == cycle) begin
        e = sb_q[i];
        sb_q.delete(i);
        tests++;
        assert (player_a === e.pa) else begin
          fails++;
          $error("FAIL %s.player_a cyc=%0d: observed %h expected %h", e.tag, cycle, player_a, e.pa);
        end
        tests++;
        assert (service_a === e.sa) else begin
          fails++;
          $error("FAIL %s.service_a cyc=%0d: observed %b expected %b", e.tag, cycle, service_a, e.sa);
        end
        tests++;
        assert (player_b === e.pb) else begin
          fails++;
          $error("FAIL %s.player_b cyc=%0d: observed %h expected %h", e.tag, cycle, player_b, e.pb);
        end
        tests++;
        assert (service_b === e.sb) else begin
          fails++;
          $error("FAIL %s.service_b cyc=%0d: observed %b expected %b", e.tag, cycle, service_b, e.sb);
        end
      end else begin
        i++;
      end
    end
  endtask

  // Queue the current expected outputs for the next edge, then advance one clock and score.
  task automatic hold(input int n);
    exp_t e;
    for (int k = 0; k < n; k++) begin
      e.cyc = cycle + 1;
      e.pa  = ea;
      e.sa  = esa;
      e.pb  = eb;
      e.sb  = esb;
      e.tag = tag;
      sb_q.push_back(e);
      @(posedge clock);
      #1;
      cycle++;
      check_due();
    end
  endtask

  task automatic ps2(input logic pressed, input logic ext, input logic [7:0] code);
    ps2_key = {~ps2_key[10], pressed, ext, code};
  endtask

  initial begin
    reset      = 1'b1;
    ps2_key    = 11'h400;
    joystick_0 = '0;
    joystick_1 = '0;
    ea = '0; esa = '0; eb = '0; esb = '0;

    tag = "reset";
    @(posedge clock);
    #1;
    cycle++;
    hold(2);
    reset = 1'b0;
    tag = "toggle_through_reset";
    hold(3);

    tag = "up1_press";
    ps2(1'b1, 1'b1, 8'h75);
    hold(1);
    ea[0] = 1'b1; eb[0] = 1'b1;
    hold(3);
    tag = "up1_release";
    ps2(1'b0, 1'b1, 8'h75);
    hold(1);
    ea[0] = 1'b0; eb[0] = 1'b0;
    hold(2);

    tag = "numpad_ignored";
    ps2(1'b1, 1'b0, 8'h75);
    hold(3);
    ps2(1'b0, 1'b0, 8'h75);
    hold(2);

    tag = "ctrl_plain";
    ps2(1'b1, 1'b0, 8'h14);
    hold(1);
    ea[4] = 1'b1; eb[4] = 1'b1;
    hold(1);
    ps2(1'b0, 1'b1, 8'h14);
    hold(1);
    ea[4] = 1'b0; eb[4] = 1'b0;
    hold(1);
    tag = "ctrl_ext";
    ps2(1'b1, 1'b1, 8'h14);
    hold(1);
    ea[4] = 1'b1; eb[4] = 1'b1;
    hold(1);
    ps2(1'b0, 1'b0, 8'h14);
    hold(1);
    ea[4] = 1'b0; eb[4] = 1'b0;
    hold(1);

    tag = "p2_up_key";
    ps2(1'b1, 1'b0, 8'h2D);
    hold(1);
    ea[10] = 1'b1;
    hold(2);
    ps2(1'b0, 1'b0, 8'h2D);
    hold(1);
    ea[10] = 1'b0;
    hold(1);

    tag = "svc1";
    ps2(1'b1, 1'b0, 8'h46);
    hold(1);
    esa = 2'b01; esb = 2'b01;
    hold(1);
    tag = "svc2";
    ps2(1'b1, 1'b0, 8'h45);
    hold(1);
    esa = 2'b11; esb = 2'b11;
    hold(1);
    ps2(1'b0, 1'b0, 8'h46);
    hold(1);
    esa = 2'b10; esb = 2'b10;
    hold(1);
    ps2(1'b0, 1'b0, 8'h45);
    hold(1);
    esa = 2'b00; esb = 2'b00;
    hold(1);

    tag = "joy_map";
    for (int i = 0; i < 8; i++) begin
      joystick_0 = 11'd1 << i;
      joystick_1 = 11'd1 << ((i + 1) % 8);
      ea = '0; eb = '0;
      ea[map_out[i]] = 1'b1;
      ea[10 + map_out[(i + 1) % 8]] = 1'b1;
      eb[map_out[i]] = 1'b1;
      hold(1);
    end
    tag = "joy_extra_bit";
    joystick_0 = 11'h400;
    joystick_1 = 11'h400;
    ea = '0; eb = '0;
    hold(2);
    joystick_0 = '0;
    joystick_1 = '0;
    hold(1);

    tag = "key_or_joy";
    ps2(1'b1, 1'b1, 8'h75);
    hold(1);
    ea[0] = 1'b1; eb[0] = 1'b1;
    hold(1);
    joystick_0 = 11'h008;
    hold(1);
    ps2(1'b0, 1'b1, 8'h75);
    hold(2);
    joystick_0 = '0;
    ea[0] = 1'b0; eb[0] = 1'b0;
    hold(2);

    tag = "coin_stretch";
    joystick_0 = 11'h100;
    ea[8] = 1'b1; eb[8] = 1'b1;
    hold(1);
    joystick_0 = '0;
    eb[8] = 1'b0;
    hold(10);
    ea[8] = 1'b0;
    hold(3);

    tag = "coin_retrigger";
    joystick_0 = 11'h100;
    ea[8] = 1'b1; eb[8] = 1'b1;
    hold(1);
    joystick_0 = '0;
    eb[8] = 1'b0;
    hold(6);
    joystick_0 = 11'h100;
    eb[8] = 1'b1;
    hold(1);
    joystick_0 = '0;
    eb[8] = 1'b0;
    hold(10);
    ea[8] = 1'b0;
    hold(2);

    tag = "pause_toggle";
    joystick_0 = 11'h200;
    ea[9] = 1'b1; eb[9] = 1'b1;
    hold(1);
    joystick_0 = '0;
    eb[9] = 1'b0;
    hold(3);
    joystick_0 = 11'h200;
    ea[9] = 1'b0; eb[9] = 1'b1;
    hold(1);
    joystick_0 = '0;
    eb[9] = 1'b0;
    hold(3);
    tag = "pause_level";
    joystick_0 = 11'h200;
    ea[9] = 1'b1; eb[9] = 1'b1;
    hold(3);
    joystick_0 = '0;
    eb[9] = 1'b0;
    hold(2);

    tag = "reset_mid";
    ps2(1'b1, 1'b1, 8'h75);
    hold(1);
    ea[0] = 1'b1; eb[0] = 1'b1;
    hold(1);
    joystick_0 = 11'h100;
    ea[8] = 1'b1; eb[8] = 1'b1;
    hold(1);
    joystick_0 = '0;
    eb[8] = 1'b0;
    hold(2);
    reset = 1'b1;
    ea = '0; esa = '0; eb = '0; esb = '0;
    hold(2);
    reset = 1'b0;
    tag = "after_reset_mid";
    hold(4);

    tag = "drain";
    for (int k = 0; k < 8 && sb_q.size() != 0; k++) begin
      @(posedge clock);
      #1;
      cycle++;
      check_due();
    end
    tests++;
    assert (sb_q.size() == 0) else begin
      fails++;
      $error("FAIL drain: observed %0d pending expectations, expected 0", sb_q.size());
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/cave_input_mapper.md
Name: cave_input_mapper

Overview:
- Parametrised successor to the inline keyboard/joystick decode in the top-level wrapper.
- Decodes MiSTer `ps2_key` events into held-key state and merges it with HPS joystick words.
- Adds three things the inline decode lacks: extended-scancode qualification, coin pulse stretching and an optional pause-toggle mode.
- Emits registered per-player control buses plus service buttons to the `Main` core.
- Sits between `hps_io` and `Main`, in the `clock` (clk_sys) domain.

Parameters:
- NUM_PLAYERS, 2, number of player buses generated; legal values 1 or 2.
- JOY_WIDTH, 11, width of each joystick input word.
- COIN_HOLD, 16'd50000, minimum coin output high time in clocks; 0 disables stretching.
- PAUSE_TOGGLE, 0, pause mode: 0 = momentary (pause follows the button); 1 = each rising edge of the raw pause flips a latch.

Ports:
- clock  in  1  system clock (clk_sys).
- reset  in  1  synchronous, active-high reset.
- ps2_key  in  11  [10] event toggle, [9] pressed, [8] extended (E0), [7:0] scancode.
- joystick_0  in  JOY_WIDTH  player 1 joystick: [0]R [1]L [2]D [3]U [4]B1 [5]B2 [6]B3 [7]start [8]coin [9]pause.
- joystick_1  in  JOY_WIDTH  player 2 joystick, same layout; ignored when NUM_PLAYERS=1.
- player  out  NUM_PLAYERS*10  per player p, bits [p*10+:10] = {pause,coin,start,b3,b2,b1,right,left,down,up}.
- service  out  2  {service_2, service_1}.

Behaviour:
- **Event detect:** register `prev_tog`. An event occurs when `ps2_key[10] != prev_tog`; `prev_tog <= ps2_key[10]` every cycle.
- **Key update:** on an event, the matching key register loads `ps2_key[9]`. Non-matching codes are ignored.
- **Key table, extended bit must be 1:** 75 up1, 72 down1, 6B left1, 74 right1.
- **Key table, extended bit must be 0:** 16 start1, 2E coin1, 29 b3_1, 11 alt/b2_1, 4D pause1, 2D up2, 2B down2, 23 left2, 34 right2, 1C b1_2, 1B b2_2, 15 b3_2, 1E start2, 36 coin2, 46 svc1, 45 svc2.
- **Ctrl (14):** matches regardless of the extended bit; maps to b1_1.
- **Numpad codes:** non-extended 75/72/6B/74 (numpad keys) do not map to anything.
- **Raw signal:** raw_x = key_x | joystick bit. Player 2 keys and joystick_1 are unused when NUM_PLAYERS=1.
- **Coin stretch (per player):** a 16-bit counter loads COIN_HOLD on a rising edge of raw coin (raw registered one cycle for edge detect) and decrements to 0.
  - coin_out = raw_coin | (cnt != 0).
  - A new rising edge while cnt>0 reloads COIN_HOLD.
  - COIN_HOLD=0: coin_out = raw_coin.
- **Pause:** PAUSE_TOGGLE=0 gives pause_out = raw_pause. PAUSE_TOGGLE=1 flips the latch on each raw rising edge; pause_out = latch.
- **Output registers:** all outputs are registered.
  - Joystick-to-output latency: 1 clock.
  - ps2 event to output: 2 clocks (key register, then output register).
  - Coin/pause edge paths use the same latency.
- **Simultaneous events:** a key and its joystick bit simply OR. Only one ps2 event exists per cycle by construction.
- **Reset:**
  - All key registers, counters, edge registers, the pause latch and all outputs go to 0.
  - `prev_tog <= ps2_key[10]` during reset, so a pre-existing toggle state never produces a spurious event after release.
  - Reset mid-stretch clears the counter immediately.
- **Held keys:** a key stays asserted until its release event. No timeout.

Test Plan:
- Reset, then toggle ps2_key[10] with {pressed=1, E0=1, 0x75} → player[0] (up1) = 1 exactly 2 clocks later. Release event → 0 two clocks after.
- Event with {pressed=1, E0=0, 0x75} → no player bit changes. Event {1,0,0x14} and {1,1,0x14} → b1_1 set in both cases.
- COIN_HOLD=10: 1-cycle joystick_0[8] pulse → player[8] high for exactly 10 clocks (plus the pulse cycle), then 0. Second pulse at count 4 → hold extends to 10 clocks from the new edge.
- PAUSE_TOGGLE=1: joystick_0[9] pulses twice → player[9] goes 1 after the first pulse, 0 after the second. PAUSE_TOGGLE=0 → follows the level.
- NUM_PLAYERS=1: joystick_1=all ones and key 0x2D pressed → `player` width is 10, no change. Service key 0x46 → service[0]=1.
- Hold ps2_key[10]=1 through reset, release reset → no event decoded. Assert reset while up1 is held → all outputs 0 next clock.
